alarm_controller: RTL and testbench

ALARM_CONTROLLER -- requirements
Module: alarm_controller

---
 rtl/alarm_pkg.sv | 30 +++
 rtl/alarm_controller_tick_gen.sv | 31 +++
 rtl/alarm_controller.sv | 153 +++++++++++++++
 tb/tb_alarm_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg: state encoding, zone constants and delay helpers shared by the alarm controller.
package alarm_pkg;

    typedef enum logic [2:0] {
        S_DISARMED    = 3'd0,
        S_EXIT_DELAY  = 3'd1,
        S_ARMED       = 3'd2,
        S_ENTRY_DELAY = 3'd3,
        S_ALARM       = 3'd4
    } state_t;

    // Zone 0 is the door that starts the entry countdown; all others are instant.
    localparam int ZONE_ENTRY = 0;

    // A zero-length delay would never tick down, so it is stretched to one second.
    function automatic logic [7:0] sec_to_load(input int sec);
        return (sec <= 0) ? 8'd1 : 8'(sec);
    endfunction

    // States that run the one-second countdown.
    function automatic logic is_countdown(input state_t s);
        return (s == S_EXIT_DELAY) || (s == S_ENTRY_DELAY) || (s == S_ALARM);
    endfunction

    // States in which the system is considered armed and records tripped zones.
    function automatic logic is_guarding(input state_t s);
        return (s == S_ARMED) || (s == S_ENTRY_DELAY) || (s == S_ALARM);
    endfunction

endpackage

// File: rtl/alarm_controller_tick_gen.sv
// tick_gen: 1 Hz strobe from the system clock, restartable so a countdown's first second is full length.
module tick_gen #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

    logic [CW-1:0] r_count;
    logic          w_wrap;

    assign w_wrap = (r_count == LAST);
    assign tick   = w_wrap;

    // Count 0..CLK_FREQ-1; restart forces 0 on the same edge the controller enters a countdown.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_count <= '0;
        end else if (w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: keypad-armed intrusion alarm with exit/entry delays, lockout and timed siren.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int         CLK_FREQ  = 50_000_000,
    parameter int         EXIT_SEC  = 10,
    parameter int         ENTRY_SEC = 5,
    parameter int         ALARM_SEC = 60,
    parameter logic [3:0] USER_CODE = 4'b1010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] code,
    input  logic       enter,
    input  logic [3:0] sensor,
    output logic       aux,
    output logic       armed,
    output logic [2:0] state,
    output logic [3:0] zones,
    output logic [7:0] remaining
);

    localparam logic [7:0] EXIT_LOAD  = sec_to_load(EXIT_SEC);
    localparam logic [7:0] ENTRY_LOAD = sec_to_load(ENTRY_SEC);
    localparam logic [7:0] ALARM_LOAD = sec_to_load(ALARM_SEC);

    state_t     r_state;
    logic       r_aux;
    logic       r_armed;
    logic [3:0] r_zones;
    logic [7:0] r_remaining;
    logic [1:0] r_fails;

    logic       w_tick;
    logic       w_valid;
    logic       w_invalid;
    logic       w_lockout;
    logic       w_instant;
    logic       w_expire;
    state_t     w_next_state;
    logic       w_load;
    logic [7:0] w_load_val;

    assign w_valid   = enter && (code == USER_CODE);
    assign w_invalid = enter && (code != USER_CODE);
    assign w_lockout = w_invalid && (r_fails >= 2'd2);
    assign w_instant = |sensor[3:1];
    assign w_expire  = w_tick && (r_remaining == 8'd1);

    tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (w_load),
        .tick    (w_tick)
    );

    // Next-state decision: valid code beats lockout, lockout beats sensors and timers.
    // NOTE: w_load must be known before the edge so the prescaler restarts on the same
    // edge that enters a countdown; that is why next-state lives in combinational logic.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        w_next_state = r_state;
        w_load       = 1'b0;
        if (w_valid) begin
            if (r_state == S_DISARMED) begin
                w_next_state = S_EXIT_DELAY;
                w_load       = 1'b1;
            end else begin
                w_next_state = S_DISARMED;
            end
        end else if (w_lockout) begin
            w_next_state = S_ALARM;
            w_load       = 1'b1;
        end else begin
            case (r_state)
                S_DISARMED:   ;
                S_EXIT_DELAY: if (w_expire) w_next_state = S_ARMED;
                S_ARMED: begin
                    if (w_instant) begin
                        w_next_state = S_ALARM;
                        w_load       = 1'b1;
                    end else if (sensor[ZONE_ENTRY]) begin
                        w_next_state = S_ENTRY_DELAY;
                        w_load       = 1'b1;
                    end
                end
                S_ENTRY_DELAY: begin
                    if (w_instant || w_expire) begin
                        w_next_state = S_ALARM;
                        w_load       = 1'b1;
                    end
                end
                S_ALARM:      if (w_expire) w_next_state = S_ARMED;
                default:      w_next_state = S_DISARMED;
            endcase
        end
    end

    // Countdown length for whichever delay state is being entered.
    always_comb begin
        case (w_next_state)
            S_EXIT_DELAY:  w_load_val = EXIT_LOAD;
            S_ENTRY_DELAY: w_load_val = ENTRY_LOAD;
            default:       w_load_val = ALARM_LOAD;
        endcase
    end

    // State, registered outputs, failure counter, zone latch and countdown.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_DISARMED;
            r_aux       <= 1'b0;
            r_armed     <= 1'b0;
            r_zones     <= '0;
            r_remaining <= '0;
            r_fails     <= '0;
        end else begin
            r_state <= w_next_state;
            r_aux   <= (w_next_state == S_ALARM);
            r_armed <= is_guarding(w_next_state);

            if (w_valid) begin
                r_fails <= '0;
            end else if (w_invalid && (r_fails != 2'd3)) begin
                r_fails <= r_fails + 2'd1;
            end

            if (w_valid && (r_state != S_DISARMED)) begin
                r_zones <= '0;
            end else if (is_guarding(r_state)) begin
                r_zones <= r_zones | sensor;
            end

            if (w_load) begin
                r_remaining <= w_load_val;
            end else if (!is_countdown(w_next_state)) begin
                r_remaining <= '0;
            end else if (w_tick) begin
                r_remaining <= r_remaining - 8'd1;
            end
        end
    end

    assign aux       = r_aux;
    assign armed     = r_armed;
    assign state     = r_state;
    assign zones     = r_zones;
    assign remaining = r_remaining;

endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed scenarios plus randomized traffic against a cycle-count reference model.
module tb_alarm_controller;

    localparam int         F       = 10;
    localparam int         EXIT_S  = 3;
    localparam int         ENTRY_S = 2;
    localparam int         ALRM_S  = 4;
    localparam logic [3:0] CODE_OK = 4'b1010;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] code;
    logic       enter;
    logic [3:0] sensor;
    logic       aux;
    logic       armed;
    logic [2:0] state;
    logic [3:0] zones;
    logic [7:0] remaining;

    // Second instance: every delay set to 0, which must behave as 1 s.
    logic       z_rst;
    logic       z_enter;
    logic [3:0] z_sensor;
    logic       z_aux;
    logic       z_armed;
    logic [2:0] z_state;
    logic [3:0] z_zones;
    logic [7:0] z_remaining;

    always #5 clk = ~clk;

    alarm_controller #(
        .CLK_FREQ (F), .EXIT_SEC (EXIT_S), .ENTRY_SEC (ENTRY_S), .ALARM_SEC (ALRM_S), .USER_CODE (CODE_OK)
    ) u_dut (
        .clk (clk), .rst (rst), .code (code), .enter (enter), .sensor (sensor),
        .aux (aux), .armed (armed), .state (state), .zones (zones), .remaining (remaining)
    );

    alarm_controller #(
        .CLK_FREQ (4), .EXIT_SEC (0), .ENTRY_SEC (0), .ALARM_SEC (0), .USER_CODE (CODE_OK)
    ) u_dut_zero (
        .clk (clk), .rst (z_rst), .code (CODE_OK), .enter (z_enter), .sensor (z_sensor),
        .aux (z_aux), .armed (z_armed), .state (z_state), .zones (z_zones), .remaining (z_remaining)
    );

    int n_err = 0;
    int n_chk = 0;

    // Reference model: state number, failure count, zone record, and time measured
    // as raw clock edges since the countdown began (no prescaler).
    int m_state, m_fails, m_zones, m_elapsed, m_dur;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int secs(input int s);
        return (s == 0) ? 1 : s;
    endfunction

    function automatic bit m_counting();
        return (m_state == 1) || (m_state == 3) || (m_state == 4);
    endfunction

    function automatic bit m_guarding();
        return (m_state == 2) || (m_state == 3) || (m_state == 4);
    endfunction

    task automatic m_enter(input int st, input int sec);
        m_state   = st;
        m_elapsed = 0;
        m_dur     = secs(sec);
    endtask

    task automatic model_reset();
        m_state = 0; m_fails = 0; m_zones = 0; m_elapsed = 0; m_dur = 0;
    endtask

    task automatic model_step(input logic [3:0] c, input logic e, input logic [3:0] s);
        bit valid, invalid, lockout, expired;
        valid   = e && (c == CODE_OK);
        invalid = e && !valid;
        lockout = invalid && (m_fails >= 2);
        if (valid) m_fails = 0;
        else if (invalid && m_fails < 3) m_fails++;
        expired = 1'b0;
        if (m_counting()) begin
            m_elapsed++;
            expired = (m_elapsed == m_dur * F);
        end
        if (valid) begin
            if (m_state == 0) m_enter(1, EXIT_S);
            else begin
                m_state = 0;
                m_zones = 0;
            end
        end else begin
            if (m_guarding()) m_zones = m_zones | int'(s);
            if (lockout) m_enter(4, ALRM_S);
            else begin
                case (m_state)
                    1: if (expired) m_state = 2;
                    2: begin
                        if (s[3:1] != 3'b000) m_enter(4, ALRM_S);
                        else if (s[0]) m_enter(3, ENTRY_S);
                    end
                    3: if (s[3:1] != 3'b000 || expired) m_enter(4, ALRM_S);
                    4: if (expired) m_state = 2;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_outputs();
        check("state", int'(state), m_state);
        check("aux", int'(aux), (m_state == 4) ? 1 : 0);
        check("armed", int'(armed), m_guarding() ? 1 : 0);
        check("zones", int'(zones), m_zones);
        check("remaining", int'(remaining), m_counting() ? (m_dur - m_elapsed / F) : 0);
    endtask

    task automatic cycle(input logic [3:0] c, input logic e, input logic [3:0] s);
        code = c; enter = e; sensor = s;
        @(posedge clk); #1;
        model_step(c, e, s);
        check_outputs();
        enter = 1'b0; sensor = 4'b0000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'b0000, 1'b0, 4'b0000);
    endtask

    task automatic do_reset();
        rst = 1'b1; enter = 1'b0; sensor = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_outputs();
    endtask

    task automatic z_step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rc, rs;
        logic       re;
        int         enter_div;

        rst = 1'b1; code = 4'b0000; enter = 1'b0; sensor = 4'b0000;
        z_rst = 1'b1; z_enter = 1'b0; z_sensor = 4'b0000;

        // Zero-length delays run as one second (4 cycles here).
        z_step(1);
        z_rst = 1'b0;
        check("z_reset_state", int'(z_state), 0);
        z_enter = 1'b1; z_step(1); z_enter = 1'b0;
        check("z_exit_state", int'(z_state), 1);
        check("z_exit_rem", int'(z_remaining), 1);
        z_step(3);
        check("z_exit_hold", int'(z_state), 1);
        z_step(1);
        check("z_armed_state", int'(z_state), 2);
        z_sensor = 4'b0001; z_step(1); z_sensor = 4'b0000;
        check("z_entry_state", int'(z_state), 3);
        check("z_entry_rem", int'(z_remaining), 1);
        z_step(4);
        check("z_alarm_aux", int'(z_aux), 1);
        z_step(4);
        check("z_rearm_state", int'(z_state), 2);
        check("z_rearm_aux", int'(z_aux), 0);
        check("z_rearm_zones", int'(z_zones), 1);

        // Reset state.
        do_reset();
        check("rst_state", int'(state), 0);
        check("rst_rem", int'(remaining), 0);

        // Arm sequence.
        cycle(CODE_OK, 1'b1, 4'b0000);
        check("arm_state", int'(state), 1);
        check("arm_rem", int'(remaining), 3);
        idle(29);
        check("exit_hold_state", int'(state), 1);
        check("exit_hold_rem", int'(remaining), 1);
        idle(1);
        check("armed_state", int'(state), 2);
        check("armed_flag", int'(armed), 1);
        check("armed_aux", int'(aux), 0);

        // Entry path to siren and automatic re-arm.
        cycle(4'b0000, 1'b0, 4'b0001);
        check("entry_state", int'(state), 3);
        check("entry_zones", int'(zones), 1);
        idle(20);
        check("entry_alarm_state", int'(state), 4);
        check("entry_alarm_aux", int'(aux), 1);
        idle(40);
        check("rearm_state", int'(state), 2);
        check("rearm_aux", int'(aux), 0);
        check("rearm_zones", int'(zones), 1);

        // Instant zone during entry delay, then disarm.
        cycle(4'b0000, 1'b0, 4'b0001);
        cycle(4'b0000, 1'b0, 4'b0100);
        check("instant_state", int'(state), 4);
        check("instant_zones", int'(zones), 5);
        cycle(CODE_OK, 1'b1, 4'b0000);
        check("disarm_state", int'(state), 0);
        check("disarm_zones", int'(zones), 0);
        check("disarm_aux", int'(aux), 0);

        // Lockout after three bad codes; a fourth keeps the siren.
        cycle(4'b0000, 1'b1, 4'b0000);
        cycle(4'b0011, 1'b1, 4'b0000);
        check("lock2_aux", int'(aux), 0);
        cycle(4'b1111, 1'b1, 4'b0000);
        check("lock3_aux", int'(aux), 1);
        cycle(4'b0101, 1'b1, 4'b0000);
        check("lock4_aux", int'(aux), 1);
        cycle(CODE_OK, 1'b1, 4'b0000);
        check("unlock_state", int'(state), 0);

        // Valid code wins over a simultaneous instant trip.
        cycle(CODE_OK, 1'b1, 4'b0000);
        idle(30);
        cycle(CODE_OK, 1'b1, 4'b0010);
        check("prio_state", int'(state), 0);
        check("prio_zones", int'(zones), 0);

        // Bad third code plus sensor trip still alarms; reset clears everything.
        cycle(4'b0000, 1'b1, 4'b0000);
        cycle(4'b0000, 1'b1, 4'b0000);
        cycle(4'b0000, 1'b1, 4'b1000);
        check("lock_trip_state", int'(state), 4);
        idle(5);
        do_reset();
        check("rst_alarm_aux", int'(aux), 0);
        check("rst_alarm_armed", int'(armed), 0);
        check("rst_alarm_zones", int'(zones), 0);

        // Reset mid-countdown.
        cycle(CODE_OK, 1'b1, 4'b0000);
        idle(15);
        do_reset();
        check("rst_mid_rem", int'(remaining), 0);

        // Randomized traffic, alternating busy and quiet keypad phases.
        for (int b = 0; b < 8; b++) begin
            enter_div = (b % 2 == 0) ? 20 : 120;
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 599) == 0) begin
                    do_reset();
                end else begin
                    re = ($urandom_range(0, enter_div - 1) == 0);
                    rc = ($urandom_range(0, 1) == 1) ? CODE_OK : 4'($urandom_range(0, 15));
                    rs = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
                    cycle(rc, re, rs);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
